// File: rtl/pixel_writer.sv
// Pixel sink: clips (x,y,color) writes, forms y*H_RES+x, and queues them for the framebuffer port.
// Optional duplicate-pixel filter is enabled by defining PIXEL_WRITER_DUP_FILTER_EN.
module pixel_writer #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int ADDR_W = 19,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic [9:0]        px_x,
    input  logic [9:0]        px_y,
    input  logic [11:0]       px_color,
    input  logic              px_rts,
    output logic              px_rtr,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [11:0]       fb_wdata,
    output logic              fb_rts,
    input  logic              fb_rtr,
    output logic              idle,
    output logic [15:0]       clip_cnt,
    output logic [15:0]       wr_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int EW = ADDR_W + 12;
    localparam logic [31:0] H_LIM = H_RES;
    localparam logic [31:0] V_LIM = V_RES;

    logic              s1_valid_q, s1_valid_d;
    logic [9:0]        s1_x_q, s1_x_d;
    logic [9:0]        s1_y_q, s1_y_d;
    logic [11:0]       s1_color_q, s1_color_d;
    logic [EW-1:0]     mem_q [DEPTH];
    logic [EW-1:0]     mem_d [DEPTH];
    logic [PW:0]       wptr_q, wptr_d;
    logic [PW:0]       rptr_q, rptr_d;
    logic [15:0]       clip_cnt_q, clip_cnt_d;
    logic [15:0]       wr_cnt_q, wr_cnt_d;

    logic [PW:0]       fifo_count_s;
    logic [PW+1:0]     occ_s;
    logic              empty_s;
    logic              accept_s;
    logic              clip_s;
    logic              dup_s;
    logic              push_s;
    logic              pop_s;
    logic [ADDR_W-1:0] s1_addr_s;
    logic [EW-1:0]     s1_entry_s;

    // Occupancy counts the stage-1 pixel too, so stage 1 can always advance without a stall path.
    assign fifo_count_s = wptr_q - rptr_q;
    assign empty_s      = (wptr_q == rptr_q);
    assign occ_s        = {1'b0, fifo_count_s} + {{(PW + 1){1'b0}}, s1_valid_q};
    assign px_rtr       = (occ_s < (PW + 2)'(DEPTH));
    assign accept_s     = px_rts & px_rtr;

    assign clip_s     = ({22'd0, s1_x_q} >= H_LIM) | ({22'd0, s1_y_q} >= V_LIM);
    assign s1_addr_s  = ADDR_W'(s1_y_q) * ADDR_W'(H_RES) + ADDR_W'(s1_x_q);
    assign s1_entry_s = {s1_addr_s, s1_color_q};
    assign push_s     = s1_valid_q & ~clip_s & ~dup_s;

    assign fb_rts              = ~empty_s;
    assign pop_s               = fb_rts & fb_rtr;
    assign {fb_addr, fb_wdata} = mem_q[rptr_q[PW-1:0]];
    assign idle                = ~s1_valid_q & empty_s;
    assign clip_cnt            = clip_cnt_q;
    assign wr_cnt              = wr_cnt_q;

`ifdef PIXEL_WRITER_DUP_FILTER_EN
    logic          last_valid_q, last_valid_d;
    logic [EW-1:0] last_q, last_d;

    assign dup_s = last_valid_q & (last_q == s1_entry_s);

    // Remember the most recently pushed {addr,color} for duplicate suppression.
    always_comb begin
        last_valid_d = last_valid_q;
        last_d       = last_q;
        if (push_s) begin
            last_valid_d = 1'b1;
            last_d       = s1_entry_s;
        end else begin
            last_valid_d = last_valid_q;
            last_d       = last_q;
        end
    end

    // Duplicate-record registers.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            last_valid_q <= 1'b0;
            last_q       <= {EW{1'b0}};
        end else begin
            last_valid_q <= last_valid_d;
            last_q       <= last_d;
        end
    end
`else
    assign dup_s = 1'b0;
`endif

    // Next-state for stage 1, FIFO and counters.
    always_comb begin
        s1_valid_d = accept_s;
        s1_x_d     = s1_x_q;
        s1_y_d     = s1_y_q;
        s1_color_d = s1_color_q;
        mem_d      = mem_q;
        wptr_d     = wptr_q + {{PW{1'b0}}, push_s};
        rptr_d     = rptr_q + {{PW{1'b0}}, pop_s};
        clip_cnt_d = clip_cnt_q;
        wr_cnt_d   = wr_cnt_q;

        if (accept_s) begin
            s1_x_d     = px_x;
            s1_y_d     = px_y;
            s1_color_d = px_color;
        end else begin
            s1_x_d     = s1_x_q;
            s1_y_d     = s1_y_q;
            s1_color_d = s1_color_q;
        end

        if (push_s) begin
            mem_d[wptr_q[PW-1:0]] = s1_entry_s;
        end else begin
            mem_d = mem_q;
        end

        if (s1_valid_q && clip_s && (clip_cnt_q != 16'hFFFF)) begin
            clip_cnt_d = clip_cnt_q + 16'd1;
        end else begin
            clip_cnt_d = clip_cnt_q;
        end

        if (pop_s) begin
            wr_cnt_d = wr_cnt_q + 16'd1;
        end else begin
            wr_cnt_d = wr_cnt_q;
        end
    end

    // State registers; reset also clears FIFO contents so fb_addr/fb_wdata read zero.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            s1_valid_q <= 1'b0;
            s1_x_q     <= 10'd0;
            s1_y_q     <= 10'd0;
            s1_color_q <= 12'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {EW{1'b0}};
            end
            wptr_q     <= {(PW + 1){1'b0}};
            rptr_q     <= {(PW + 1){1'b0}};
            clip_cnt_q <= 16'd0;
            wr_cnt_q   <= 16'd0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_x_q     <= s1_x_d;
            s1_y_q     <= s1_y_d;
            s1_color_q <= s1_color_d;
            mem_q      <= mem_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            clip_cnt_q <= clip_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
        end
    end
endmodule
